// File: rtl/pipecleaner_pkg.sv
// Shared types and constants for the Pipecleaner uio bus arbiter.
package pipecleaner_pkg;

  localparam int UIO_W          = 8;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_MAX_HOLD   = 16;
  localparam int DEF_TURNAROUND = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational cyclic priority picker: first eligible requester strictly after ptr.
module rr_pick
  import pipecleaner_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [N_REQ-1:0] excl,
  output logic [N_REQ-1:0] win,
  output logic [PTR_W-1:0] win_idx,
  output logic             found
);

  logic [N_REQ-1:0] cand;

  assign cand = req & ~excl;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    // Wrapped group (at or below ptr) first, then the group above ptr overrides it;
    // the descending scan leaves the lowest index of the winning group.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[i] && (i <= int'(ptr))) begin
        win     = '0;
        win[i]  = 1'b1;
        win_idx = PTR_W'(i);
        found   = 1'b1;
      end
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[i] && (i > int'(ptr))) begin
        win     = '0;
        win[i]  = 1'b1;
        win_idx = PTR_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner arbitration of the shared uio pads with hold limit and
// an all-input turnaround gap between successive owners.
module uio_bus_arbiter
  import pipecleaner_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int MAX_HOLD   = DEF_MAX_HOLD,
  parameter int TURNAROUND = DEF_TURNAROUND
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       dir,
  input  logic [UIO_W*N_REQ-1:0] wdata,
  input  logic [UIO_W-1:0]       uio_in,
  output logic [N_REQ-1:0]       grant,
  output logic [UIO_W-1:0]       rdata,
  output logic                   rvalid,
  output logic [UIO_W-1:0]       uio_out,
  output logic [UIO_W-1:0]       uio_oe,
  output logic                   busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HC_W  = $clog2(MAX_HOLD + 1);
  localparam int TC_W  = $clog2(TURNAROUND + 1);

  arb_state_t       state, state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [HC_W-1:0]  hold_cnt, hold_nxt;
  logic [TC_W-1:0]  turn_cnt;
  logic [N_REQ-1:0] win;
  logic [PTR_W-1:0] win_idx;
  logic             found;
  logic             take, others, turn_last, rel_own;
  logic [UIO_W-1:0] wslice [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign wslice[g] = wdata[g*UIO_W +: UIO_W];
  end

  // ptr doubles as the owner index, so the last owner naturally ranks last next time.
  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .excl    ({N_REQ{1'b0}}),
    .win     (win),
    .win_idx (win_idx),
    .found   (found)
  );

  assign others    = |(req & ~grant);
  assign hold_nxt  = (hold_cnt == HC_W'(MAX_HOLD)) ? HC_W'(1) : hold_cnt + HC_W'(1);
  assign turn_last = (turn_cnt == TC_W'(TURNAROUND - 1));
  // hold_nxt counts the current OWN cycle, so release lands right after the MAX_HOLD-th one.
  assign rel_own   = !req[ptr] || !ena || ((hold_nxt == HC_W'(MAX_HOLD)) && others);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= PTR_W'(N_REQ - 1);
      hold_cnt <= '0;
      turn_cnt <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rdata    <= uio_in;
      rvalid   <= (state == OWN) && !dir[ptr];
      turn_cnt <= (state == TURN) ? turn_cnt + TC_W'(1) : '0;
      if (take) begin
        grant    <= win;
        ptr      <= win_idx;
        hold_cnt <= '0;
      end else if (state_nxt == OWN) begin
        hold_cnt <= hold_nxt;
      end else begin
        grant    <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (ena && found) begin
          state_nxt = OWN;
          take      = 1'b1;
        end
      end
      OWN: begin
        if (rel_own) state_nxt = TURN;
      end
      TURN: begin
        if (turn_last) begin
          if (ena && found) begin
            state_nxt = OWN;
            take      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pads follow the registered owner's live dir/wdata.
  always_comb begin
    uio_oe  = '0;
    uio_out = '0;
    busy    = (state != IDLE);
    if (state == OWN) begin
      uio_out = wslice[ptr];
      if (dir[ptr]) uio_oe = '1;
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: two instances (turnaround 1 and 3) checked against a tenure-level model.
module tb_uio_bus_arbiter;

  localparam int NR   = 4;
  localparam int MH   = 4;
  localparam int TA_A = 1;
  localparam int TA_B = 3;

  logic            clk = 1'b0;
  logic            rst, ena;
  logic [NR-1:0]   req, dir;
  logic [8*NR-1:0] wdata;
  logic [7:0]      uio_in;

  logic [NR-1:0] grant_a, grant_b;
  logic [7:0]    rdata_a, rdata_b, uio_out_a, uio_out_b, uio_oe_a, uio_oe_b;
  logic          rvalid_a, rvalid_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  int         m_owner [2];
  int         m_quiet [2];
  int         m_last  [2];
  int         m_ten   [2];
  logic [7:0] m_rd    [2];
  logic       m_rv    [2];

  logic [3:0] order_q [$];
  logic [3:0] prev_g = '0;
  bit         rec_on = 1'b0;
  logic [3:0] gs     [6];
  logic [3:0] exp_gs [6];
  logic [3:0] exp_order [5];
  int         cnt, gap_a, gap_b;

  always #5 clk = ~clk;

  uio_bus_arbiter #(.N_REQ(NR), .MAX_HOLD(MH), .TURNAROUND(TA_A)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .dir(dir), .wdata(wdata), .uio_in(uio_in),
    .grant(grant_a), .rdata(rdata_a), .rvalid(rvalid_a), .uio_out(uio_out_a),
    .uio_oe(uio_oe_a), .busy(busy_a)
  );

  uio_bus_arbiter #(.N_REQ(NR), .MAX_HOLD(MH), .TURNAROUND(TA_B)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .dir(dir), .wdata(wdata), .uio_in(uio_in),
    .grant(grant_b), .rdata(rdata_b), .rvalid(rvalid_b), .uio_out(uio_out_b),
    .uio_oe(uio_oe_b), .busy(busy_b)
  );

  function automatic int ta_of(input int k);
    return (k == 0) ? TA_A : TA_B;
  endfunction

  function automatic int pick(input int last, input logic [NR-1:0] r);
    for (int d = 1; d <= NR; d++) begin
      if (r[(last + d) % NR]) return (last + d) % NR;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tenure-level model: an owner (or none), a quiet countdown, and the last winner.
  task automatic model_step(input int k);
    logic [NR-1:0] oth;
    if (rst) begin
      m_owner[k] = -1; m_quiet[k] = 0; m_last[k] = NR - 1; m_ten[k] = 0;
      m_rd[k] = '0; m_rv[k] = 1'b0;
      return;
    end
    m_rv[k] = (m_owner[k] >= 0) && !dir[m_owner[k]];
    m_rd[k] = uio_in;
    if (m_owner[k] >= 0) begin
      oth = req;
      oth[m_owner[k]] = 1'b0;
      m_ten[k]++;
      if (!req[m_owner[k]] || !ena || ((m_ten[k] % MH == 0) && (oth != '0))) begin
        m_owner[k] = -1;
        m_quiet[k] = ta_of(k);
      end
    end else begin
      if (m_quiet[k] > 0) m_quiet[k]--;
      if (m_quiet[k] == 0 && ena && req != '0) begin
        m_owner[k] = pick(m_last[k], req);
        m_last[k]  = m_owner[k];
        m_ten[k]   = 0;
      end
    end
  endtask

  task automatic cmp(input int k, input logic [3:0] g, input logic [7:0] oe, input logic [7:0] out,
                     input logic [7:0] rd, input logic rv, input logic bs);
    string p;
    int o;
    logic [3:0] eg;
    logic [7:0] eoe, eout;
    p = (k == 0) ? "a" : "b";
    o = m_owner[k];
    eg = '0; eoe = '0; eout = '0;
    if (o >= 0) begin
      eg[o] = 1'b1;
      eout  = wdata[o*8 +: 8];
      if (dir[o]) eoe = 8'hFF;
    end
    chk({p, ".grant"},   32'(g),  32'(eg));
    chk({p, ".uio_oe"},  32'(oe), 32'(eoe));
    chk({p, ".uio_out"}, 32'(out), 32'(eout));
    chk({p, ".rdata"},   32'(rd), 32'(m_rd[k]));
    chk({p, ".rvalid"},  32'(rv), 32'(m_rv[k]));
    chk({p, ".busy"},    32'(bs), 32'((o >= 0) || (m_quiet[k] > 0)));
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      cmp(0, grant_a, uio_oe_a, uio_out_a, rdata_a, rvalid_a, busy_a);
      cmp(1, grant_b, uio_oe_b, uio_out_b, rdata_b, rvalid_b, busy_b);
    end
  end

  always @(negedge clk) begin
    if (rec_on && grant_a != '0 && grant_a != prev_g) order_q.push_back(grant_a);
    prev_g = grant_a;
  end

  a_oe_a: assert property (@(negedge clk) disable iff (!started) (uio_oe_a != 8'h00) |-> (grant_a != 4'h0))
    else $error("pads driven without grant on instance a");
  a_oe_b: assert property (@(negedge clk) disable iff (!started) (uio_oe_b != 8'h00) |-> (grant_b != 4'h0))
    else $error("pads driven without grant on instance b");

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; dir = '0; ena = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; req = '0; dir = '0; wdata = '0; uio_in = '0;
    tick(2);
    @(negedge clk);
    chk("lit.rst_grant", 32'(grant_a), 32'h0);
    chk("lit.rst_busy",  32'(busy_a),  32'h0);
    chk("lit.rst_oe",    32'(uio_oe_b), 32'h0);

    // First grant from idle and a mid-tenure reset pulse
    tick(1);
    rst = 1'b0; ena = 1'b1; req = 4'b0001; dir = 4'b0001; wdata[7:0] = 8'hA5; uio_in = 8'h77;
    tick(1);
    @(negedge clk);
    chk("lit.first_grant", 32'(grant_a),   32'h1);
    chk("lit.first_oe",    32'(uio_oe_a),  32'hFF);
    chk("lit.first_out",   32'(uio_out_a), 32'hA5);
    chk("lit.first_grant_b", 32'(grant_b), 32'h1);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("lit.rstpulse_grant", 32'(grant_a),   32'h0);
    chk("lit.rstpulse_oe",    32'(uio_oe_a),  32'h0);
    chk("lit.rstpulse_out",   32'(uio_out_a), 32'h0);
    chk("lit.rstpulse_rdata", 32'(rdata_a),   32'h0);
    chk("lit.rstpulse_busy",  32'(busy_a),    32'h0);

    // Round robin over all four, each owner dropping req after 3 cycles
    do_reset();
    wdata = 32'hC3B2_A191; uio_in = 8'h00;
    req = 4'b1111; rec_on = 1'b1;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      tick(2);
      req[k] = 1'b0;
      tick(1);
      req[k] = 1'b1;
      tick(1);
    end
    tick(1);
    rec_on = 1'b0;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("lit.rr_count", 32'(order_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("lit.rr_order", (i < order_q.size()) ? 32'(order_q[i]) : 32'hDEAD, 32'(exp_order[i]));
    end

    // Hold limit: owner 2 forced off after 4 OWN cycles when owner 3 waits
    do_reset();
    req = 4'b0100; dir = 4'b0100; wdata[23:16] = 8'h5A;
    tick(1);
    req[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gs[i] = grant_a;
    end
    exp_gs = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000};
    for (int i = 0; i < 6; i++) chk("lit.hold_seq", 32'(gs[i]), 32'(exp_gs[i]));

    // Sole requester keeps the bus past the hold limit; dir/wdata change mid-tenure
    do_reset();
    req = 4'b0100;
    tick(1);
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (grant_a == 4'b0100) cnt++;
      @(posedge clk);
      #2;
      dir[2] = (i % 2) == 1;
      wdata[23:16] = 8'(i * 13 + 1);
    end
    chk("lit.sole_hold", 32'(cnt), 32'd24);

    // Read owner: pads released, rdata/rvalid one cycle later
    do_reset();
    req = 4'b0010; dir = 4'b0000; uio_in = 8'h3C;
    tick(1);
    @(negedge clk);
    chk("lit.read_oe",    32'(uio_oe_a), 32'h0);
    chk("lit.read_grant", 32'(grant_a),  32'h2);
    @(negedge clk);
    chk("lit.read_rdata",  32'(rdata_a),  32'h3C);
    chk("lit.read_rvalid", 32'(rvalid_a), 32'h1);
    tick(1);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    chk("lit.turn_busy_b",   32'(busy_b),   32'h1);
    chk("lit.turn_grant_b",  32'(grant_b),  32'h0);
    chk("lit.turn_rvalid_b", 32'(rvalid_b), 32'h0);

    // ena drop during OWN
    do_reset();
    req = 4'b0001; dir = 4'b0001;
    tick(1);
    ena = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("lit.ena_turn_grant", 32'(grant_a), 32'h0);
    chk("lit.ena_turn_busy",  32'(busy_a),  32'h1);
    @(negedge clk);
    chk("lit.ena_idle_busy", 32'(busy_a), 32'h0);
    tick(1);
    ena = 1'b1;
    @(negedge clk);
    chk("lit.ena_wait_grant", 32'(grant_a), 32'h0);
    @(negedge clk);
    chk("lit.ena_regrant", 32'(grant_a), 32'h1);

    // Handover gap width for both turnaround settings
    do_reset();
    req = 4'b0001; dir = 4'b1111;
    tick(1);
    req = 4'b0010;
    gap_a = 0; gap_b = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grant_a == '0 && uio_oe_a == 8'h00) gap_a++;
      if (grant_b == '0 && uio_oe_b == 8'h00) gap_b++;
    end
    chk("lit.gap_a", 32'(gap_a), 32'd1);
    chk("lit.gap_b", 32'(gap_b), 32'd3);
    chk("lit.gap_next_owner_b", 32'(grant_b), 32'h2);

    tick(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
